mem_port_arbiter: RTL and testbench

//  Shares the single-port unified instruction/data memory between the fetch unit and the

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/rr_arb2.sv | 18 +
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and memwrite encodings for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam logic [1:0] MW_NONE  = 2'b00;
  localparam logic [1:0] MW_WORD  = 2'b01;
  localparam logic [1:0] MW_DWORD = 2'b10;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin picker; bit 0 = fetch, bit 1 = data
//   clk, reset (async, active-low) | req_i: request levels | upd_i: commit the
//   current pick as last winner | gnt_o: one-hot pick (00 when idle)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);
  owner_t last_q;
  assign gnt_o = &req_i ? (last_q == OWN_IF ? 2'b10 : 2'b01) : req_i;
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= OWN_IF;
    else if (upd_i) last_q <= gnt_o[1] ? OWN_D : OWN_IF;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store
//   clk, reset (async, active-low)
//   fetch: if_req/if_addr in, if_gnt/if_rvalid/if_rdata out
//   data : d_req/d_we/d_addr/d_wdata in, d_gnt/d_rvalid/d_rdata out
//   memory: mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in | busy out
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic [1:0]    d_we,
  input  logic [63:0]   d_addr,
  input  logic [63:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [63:0]   d_rdata,
  output logic          mem_en,
  output logic [1:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata,
  output logic          busy
);
  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);
  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    we_q, we_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [63:0]   d_rdata_q, d_rdata_d;
  logic [1:0]    gnt;
  logic          pick;
  logic [63:0]   req_addr;
  logic          unused_addr;
  assign pick        = state_q == S_IDLE && (if_req || d_req);
  assign req_addr    = gnt[1] ? d_addr : {32'b0, if_addr};
  assign unused_addr = ^req_addr;
  rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req_i ({d_req, if_req}),
    .upd_i (pick),
    .gnt_o (gnt)
  );
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      S_IDLE: if (pick) begin
        state_d = S_ACCESS;
        owner_d = gnt[1] ? OWN_D : OWN_IF;
        addr_d  = req_addr[AW-1:0];
        we_d    = !gnt[1] || d_we == MW_NONE ? MW_NONE : d_we == MW_WORD ? MW_WORD : MW_DWORD;
        wdata_d = gnt[1] ? d_wdata : wdata_q;
      end
      S_ACCESS: begin
        state_d = we_q == MW_NONE ? S_WAIT : S_IDLE;
        cnt_d   = '0;
      end
      S_WAIT: if (cnt_q == LAST) begin
        state_d = S_RESP;
        if (owner_q == OWN_IF) if_rdata_d = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        else d_rdata_d = mem_rdata;
      end else cnt_d = cnt_q + 3'd1;
      S_RESP: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= MW_NONE;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  assign mem_en    = state_q == S_ACCESS;
  assign mem_we    = mem_en ? we_q : MW_NONE;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_gnt    = mem_en && owner_q == OWN_IF;
  assign d_gnt     = mem_en && owner_q == OWN_D;
  assign if_rvalid = state_q == S_RESP && owner_q == OWN_IF;
  assign d_rvalid  = state_q == S_RESP && owner_q == OWN_D;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = state_q != S_IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for mem_port_arbiter at MEM_LAT 1 and 3
module tb_mem_port_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [1:0]  d_we = '0;
  logic [63:0] d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, busy;
  logic [31:0] if_rdata, mem_addr;
  logic [63:0] d_rdata, mem_wdata;
  logic [1:0]  mem_we;
  logic        l3_if_gnt, l3_if_rvalid, l3_d_gnt, l3_d_rvalid, l3_mem_en, l3_busy;
  logic [31:0] l3_if_rdata, l3_mem_addr;
  logic [63:0] l3_d_rdata, l3_mem_wdata;
  logic [1:0]  l3_mem_we;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(32), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  mem_port_arbiter #(.AW(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_gnt(l3_if_gnt),
    .if_rvalid(l3_if_rvalid), .if_rdata(l3_if_rdata), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(l3_d_gnt), .d_rvalid(l3_d_rvalid),
    .d_rdata(l3_d_rdata), .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
    .mem_wdata(l3_mem_wdata), .mem_rdata(mem_rdata), .busy(l3_busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {58'b0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, busy}, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask
  task automatic do_fetch(input string tag, input logic [31:0] a, input logic [63:0] rd,
                          input logic [31:0] exp);
    mem_rdata = rd;
    if_addr   = a;
    if_req    = 1'b1;
    tick();
    chk({tag, "_gnt"}, {60'b0, if_gnt, mem_en, mem_we}, 64'b1100);
    chk({tag, "_addr"}, mem_addr, a);
    if_req = 1'b0;
    tick();
    chk({tag, "_wait"}, {62'b0, if_rvalid, busy}, 64'b01);
    tick();
    chk({tag, "_rvalid"}, if_rvalid, 1);
    chk({tag, "_rdata"}, if_rdata, exp);
    tick();
    chk({tag, "_done"}, {62'b0, if_rvalid, busy}, 0);
  endtask
  task automatic do_store(input string tag, input logic [1:0] we, input logic [63:0] a,
                          input logic [63:0] wd, input logic [1:0] exp_we, input logic [31:0] exp_a);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    tick();
    chk({tag, "_gnt"}, {62'b0, d_gnt, mem_en}, 64'b11);
    chk({tag, "_we"}, mem_we, exp_we);
    chk({tag, "_addr"}, mem_addr, exp_a);
    chk({tag, "_wdata"}, mem_wdata, wd);
    d_req = 1'b0;
    tick();
    chk({tag, "_after"}, {61'b0, busy, d_rvalid, mem_en}, 0);
    tick();
    chk({tag, "_norv"}, d_rvalid, 0);
  endtask
  initial begin
    bit q[$];
    int bad;
    repeat (3) tick();
    chk_zero("rst");
    reset = 1'b1;
    tick();
    do_fetch("f4", 32'h4, 64'h11111111_22222222, 32'h11111111);
    repeat (6) tick();
    do_fetch("f0", 32'h0, 64'h11111111_22222222, 32'h22222222);
    repeat (6) tick();
    if_addr = 32'h8;
    d_we    = 2'b01;
    d_addr  = 64'h40;
    if_req  = 1'b1;
    d_req   = 1'b1;
    for (int c = 0; c < 40 && q.size() < 4; c++) begin
      tick();
      if (d_gnt) q.push_back(1'b1);
      else if (if_gnt) q.push_back(1'b0);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    chk("rr_count", q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_gnt%0d", i), i < q.size() ? {63'b0, q[i]} : 64'hdead, (i % 2 == 0) ? 1 : 0);
    repeat (12) tick();
    do_store("st10", 2'b10, 64'hDEAD0000_00000084, 64'h7, 2'b10, 32'h84);
    repeat (6) tick();
    do_store("st11", 2'b11, 64'h90, 64'hA5A5_0000_1234_5678, 2'b10, 32'h90);
    repeat (6) tick();
    do_store("st01", 2'b01, 64'h94, 64'h0BAD_F00D, 2'b01, 32'h94);
    repeat (6) tick();
    d_we      = 2'b00;
    d_addr    = 64'd128;
    d_req     = 1'b1;
    mem_rdata = 64'h1000_0000_0000_0000;
    for (int i = 1; i <= 6; i++) begin
      tick();
      mem_rdata = 64'h1000_0000_0000_0000 + 64'(i);
      if (i == 1) begin
        chk("l3_gnt", {62'b0, l3_d_gnt, l3_mem_en}, 64'b11);
        chk("l3_addr", l3_mem_addr, 32'd128);
        d_req = 1'b0;
      end
      chk($sformatf("l3_rvalid_c%0d", i), l3_d_rvalid, i == 5);
      chk($sformatf("l1_rvalid_c%0d", i), d_rvalid, i == 3);
      if (i == 5) chk("l3_rdata", l3_d_rdata, 64'h1000_0000_0000_0004);
      if (i == 3) chk("l1_rdata", d_rdata, 64'h1000_0000_0000_0002);
    end
    repeat (8) tick();
    mem_rdata = 64'h77777777_88888888;
    if_addr   = 32'h0;
    if_req    = 1'b1;
    tick();
    if_req = 1'b0;
    tick();
    tick();
    chk("drop_f_rvalid", if_rvalid, 1);
    d_we   = 2'b00;
    d_addr = 64'h200;
    d_req  = 1'b1;
    tick();
    d_req = 1'b0;
    bad   = 0;
    for (int i = 0; i < 6; i++) begin
      if (d_gnt || d_rvalid || mem_en) bad++;
      tick();
    end
    chk("drop_no_access", bad, 0);
    repeat (8) tick();
    mem_rdata = 64'h33333333_44444444;
    if_addr   = 32'h4;
    if_req    = 1'b1;
    tick();
    if_req = 1'b0;
    tick();
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk_zero("midrst");
    tick();
    tick();
    reset = 1'b1;
    bad   = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (if_rvalid || d_rvalid || busy) bad++;
    end
    chk("midrst_quiet", bad, 0);
    do_fetch("frel", 32'h0, 64'h55555555_66666666, 32'h66666666);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
